board_scanner: RTL

Reads a finished L-bit Life board and streams it out one cell per handshake in raster order (x fastest), with cell coordinates attached. It sits downstream of the board generator and the generation engine, and feeds the display and UART dump paths. While streaming, it counts live cells. At end of scan it reports the population and a 2-bit density class that uses the same 0/1/2/3 encoding as the generator's density control, so a bench can close the loop on generated boards.

---
 rtl/board_pkg.sv | 33 +++
 rtl/board_scanner_raster_counter.sv | 41 ++++
 rtl/board_scanner.sv | 109 ++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// Shared definitions for the Life board datapath: scanner FSM states and the
// density class encoding also used by the board generator's density control.
package board_pkg;

    localparam int BOARD_W = 32;
    localparam int BOARD_H = 24;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        DONE = 2'd2
    } scan_state_t;

    typedef enum logic [1:0] {
        DENSITY_SPARSE = 2'd0,
        DENSITY_LOW    = 2'd1,
        DENSITY_MEDIUM = 2'd2,
        DENSITY_HIGH   = 2'd3
    } density_t;

    // Thresholds are integer floors of L/8, 3L/8 and 5L/8.
    function automatic density_t density_of(input int unsigned count, input int unsigned cells);
        if (count < cells / 8)
            return DENSITY_SPARSE;
        else if (count < (3 * cells) / 8)
            return DENSITY_LOW;
        else if (count < (5 * cells) / 8)
            return DENSITY_MEDIUM;
        else
            return DENSITY_HIGH;
    endfunction

endpackage

// File: rtl/board_scanner_raster_counter.sv
// Raster-order x/y position counter (x fastest) with clear, advance enable
// and a flag marking the final cell of the frame.
module raster_counter #(
    parameter int W = 32,
    parameter int H = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    output logic [$clog2(W)-1:0] x,
    output logic [$clog2(H)-1:0] y,
    output logic                 last
);

    localparam int X_W = $clog2(W);
    localparam int Y_W = $clog2(H);
    localparam logic [X_W-1:0] X_MAX = X_W'(W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(H - 1);

    // Clear wins over advance so a restart always begins at the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x == X_MAX) begin
                x <= '0;
                y <= (y == Y_MAX) ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

    assign last = (x == X_MAX) && (y == Y_MAX);

endmodule

// File: rtl/board_scanner.sv
// Streams a captured Life board one cell per handshake in raster order and
// reports the live-cell population and density class at the end of each scan.
module board_scanner
    import board_pkg::*;
#(
    parameter int W = BOARD_W,
    parameter int H = BOARD_H
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [W*H-1:0]           board_in,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_cell,
    output logic [$clog2(W)-1:0]     out_x,
    output logic [$clog2(H)-1:0]     out_y,
    output logic                     out_last,
    output logic                     done,
    output logic [$clog2(W*H+1)-1:0] live_count,
    output logic [1:0]               density_class
);

    localparam int L     = W * H;
    localparam int CNT_W = $clog2(L + 1);
    localparam int IDX_W = $clog2(L);

    scan_state_t      state;
    logic [L-1:0]     shadow;
    logic [CNT_W-1:0] run_count;
    logic [CNT_W-1:0] next_count;
    logic [IDX_W-1:0] cell_idx;
    logic             cell_bit;
    logic             at_last;
    logic             fire;
    logic             pos_clear;
    logic             pos_advance;

    assign fire        = out_valid & out_ready;
    assign pos_clear   = ((state == IDLE) && load) || (state == DONE);
    assign pos_advance = fire & ~at_last;

    raster_counter #(
        .W(W),
        .H(H)
    ) u_raster (
        .clk     (clk),
        .rst     (rst),
        .clear   (pos_clear),
        .advance (pos_advance),
        .x       (out_x),
        .y       (out_y),
        .last    (at_last)
    );

    assign cell_idx   = IDX_W'(out_y) * IDX_W'(W) + IDX_W'(out_x);
    assign cell_bit   = shadow[cell_idx];
    assign out_cell   = out_valid & cell_bit;
    assign out_last   = out_valid & at_last;
    assign next_count = run_count + CNT_W'(cell_bit);

    // Results are published on the final handshake so they are already valid
    // during the DONE cycle alongside the done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shadow        <= '0;
            run_count     <= '0;
            busy          <= 1'b0;
            out_valid     <= 1'b0;
            done          <= 1'b0;
            live_count    <= '0;
            density_class <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (load) begin
                        shadow    <= board_in;
                        run_count <= '0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (fire) begin
                        run_count <= next_count;
                        if (at_last) begin
                            out_valid     <= 1'b0;
                            done          <= 1'b1;
                            live_count    <= next_count;
                            density_class <= density_of(32'(next_count), 32'(L));
                            state         <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
